// File: rtl/gcd.sv
// ============================================================================
// Module   : gcd
// Brief    : Iterative binary (Stein) GCD engine for two unsigned 32-bit
//            operands with a start/busy/valid handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  k_q, k_d;

    logic [31:0] w_a_minus_b;
    logic [31:0] w_b_minus_a;

    assign w_a_minus_b = a_q - b_q;
    assign w_b_minus_a = b_q - a_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            k_q      <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    k_d     = 5'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Difference of two odd values is even, so it is halved in the same step.
                if (a_q == 32'd0) begin
                    result_d = b_q << k_q;
                    state_d  = DONE;
                end else if (b_q == 32'd0) begin
                    result_d = a_q << k_q;
                    state_d  = DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 5'd1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    a_d = w_a_minus_b >> 1;
                end else begin
                    b_d = w_b_minus_a >> 1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from state, so they can never overlap.
    assign busy_o   = (state_q == CALC);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd.sv
// ============================================================================
// Module   : tb_gcd
// Brief    : Directed self-checking bench for the gcd engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gcd;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int n_vec;
    int n_err;

    gcd u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Euclid by remainder: independent of the shift/subtract method in the DUT.
    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 32'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Accept one operation (start held for hold_cycles edges), then wait for valid.
    // cyc = cycles from the accepting edge to valid_o high (70 means timed out).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold_cycles,
                         output logic [31:0] res, output int cyc, output logic busy_seen);
        @(negedge clk_i);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        for (int i = 0; i < hold_cycles; i++) @(negedge clk_i);
        start_i   = 1'b0;
        busy_seen = busy_o;
        cyc       = hold_cycles - 1;
        while (!valid_o && cyc < 70) begin
            @(negedge clk_i);
            cyc++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int          c;
        logic        bs;
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        @(negedge clk_i);
        n_vec++;
        if ({busy_o, valid_o, result_o} !== {1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: busy=%b valid=%b result=%0d, want 0 0 0", busy_o, valid_o, result_o);
        end
        rst_i = 1'b0;
        // Give a result so the abort check can see result_o clear.
        do_op(32'd48, 32'd18, 1, r, c, bs);
        @(negedge clk_i);
        a_i     = 32'hFFFF_FFFF;
        b_i     = 32'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_midcalc_busy: busy=%b, want 1", busy_o);
        end
        #2 rst_i = 1'b1;
        #1;
        n_vec++;
        if ({busy_o, valid_o, result_o} !== {1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_async: busy=%b valid=%b result=%0d, want 0 0 0", busy_o, valid_o, result_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        n_vec++;
        if ({busy_o, valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b valid=%b after abort, want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        int          c;
        logic        bs;
        do_op(32'd48, 32'd18, 2, r, c, bs);
        n_vec++;
        if (bs !== 1'b1 || r !== 32'd6 || c > 65) begin
            n_err++;
            $display("FAIL basic_48_18: result=%0d busy=%b cycles=%0d, want 6 1 <=65", r, bs, c);
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_with_valid: busy=%b, want 0", busy_o);
        end
        do_op(32'd1071, 32'd462, 1, r, c, bs);
        n_vec++;
        if (r !== 32'd21 || c > 65) begin
            n_err++;
            $display("FAIL basic_1071_462: result=%0d cycles=%0d, want 21 <=65", r, c);
        end
        do_op(32'd1, 32'd1000, 1, r, c, bs);
        n_vec++;
        if (r !== 32'd1) begin
            n_err++;
            $display("FAIL basic_1_x: result=%0d, want 1", r);
        end
    endtask

    task automatic test_zero_equal();
        logic [31:0] ta[4];
        logic [31:0] tb[4];
        logic [31:0] te[4];
        int          tc[4];
        logic [31:0] r;
        int          c;
        logic        bs;
        ta = '{32'd0, 32'd17, 32'd0, 32'd12345};
        tb = '{32'd17, 32'd0, 32'd0, 32'd12345};
        te = '{32'd17, 32'd17, 32'd0, 32'd12345};
        tc = '{1, 1, 1, -1};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1, r, c, bs);
            n_vec++;
            if (r !== te[i] || (tc[i] >= 0 && c != tc[i]) || c > 65) begin
                n_err++;
                $display("FAIL zero_equal_%0d: gcd(%0d,%0d)=%0d in %0d cycles, want %0d (cycles %0d)",
                         i, ta[i], tb[i], r, c, te[i], tc[i]);
            end
        end
    endtask

    task automatic test_worst_case();
        logic [31:0] r;
        int          c;
        logic        bs;
        do_op(32'hFFFF_FFFF, 32'd1, 1, r, c, bs);
        n_vec++;
        if (r !== 32'd1 || c > 65) begin
            n_err++;
            $display("FAIL worst_ffffffff_1: result=%h cycles=%0d, want 00000001 <=65", r, c);
        end
        do_op(32'h8000_0000, 32'hC000_0000, 1, r, c, bs);
        n_vec++;
        if (r !== 32'h4000_0000 || c > 65) begin
            n_err++;
            $display("FAIL worst_pow2: result=%h cycles=%0d, want 40000000 <=65", r, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int          c;
        logic        bs;
        do_op(32'd100, 32'd75, 1, r, c, bs);
        n_vec++;
        if (r !== 32'd25 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: result=%0d valid=%b, want 25 1", r, valid_o);
        end
        @(negedge clk_i);
        a_i     = 32'd1071;
        b_i     = 32'd462;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n_vec++;
        if ({valid_o, busy_o} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_valid_drop: valid=%b busy=%b after accept, want 0 1", valid_o, busy_o);
        end
        // Disturb operands and pulse start while busy.
        @(negedge clk_i);
        a_i     = 32'd64;
        b_i     = 32'd48;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        c = 0;
        while (!valid_o && c < 70) begin
            n_vec++;
            if (busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_busy_hold: busy=%b before valid, want 1", busy_o);
            end
            @(negedge clk_i);
            c++;
        end
        n_vec++;
        if (valid_o !== 1'b1 || result_o !== 32'd21) begin
            n_err++;
            $display("FAIL b2b_ignore_busy_inputs: valid=%b result=%0d, want 1 21", valid_o, result_o);
        end
        repeat (3) @(negedge clk_i);
        n_vec++;
        if (valid_o !== 1'b1 || result_o !== 32'd21) begin
            n_err++;
            $display("FAIL b2b_sticky: valid=%b result=%0d, want 1 21", valid_o, result_o);
        end
    endtask

    task automatic test_regression();
        logic [31:0] a, b, e, m, r;
        int          c;
        logic        bs;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) begin
                // Shared factor keeps the interesting shift/subtract paths busy.
                m = $urandom_range(1, 4096);
                a = $urandom_range(1, 65535) * m;
                b = $urandom_range(1, 65535) * m;
            end
            e = ref_gcd(a, b);
            do_op(a, b, 1, r, c, bs);
            n_vec++;
            if (r !== e || c > 65) begin
                n_err++;
                $display("FAIL regress_%0d: gcd(%h,%h)=%h in %0d cycles, want %h", i, a, b, r, c, e);
                break;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_zero_equal();
        test_worst_case();
        test_back_to_back();
        test_regression();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    always @(negedge clk_i) begin
        if (busy_o && valid_o) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_valid_exclusive: busy=%b valid=%b, want not both 1", busy_o, valid_o);
        end
    end

endmodule

`default_nettype wire
